// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the decode/execute datapath and the
// pipeline hazard controller: operand/hazard inputs, redirect and debug
// requests, and the stall/flush/ack/perf-counter responses.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       RS1_ID;
  logic [4:0]       RS2_ID;
  logic             USE_RS1_ID;
  logic             USE_RS2_ID;
  logic [4:0]       RD_DE;
  logic [1:0]       MemRead_DE;
  logic             BR_TAKEN_E;
  logic             HALT_REQ;
  logic             CNT_CLR;
  logic             stall_PC;
  logic             stall_FD;
  logic             flush_FD;
  logic             flush_DE;
  logic             HALT_ACK;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    output RS1_ID, RS2_ID, USE_RS1_ID, USE_RS2_ID, RD_DE, MemRead_DE,
           BR_TAKEN_E, HALT_REQ, CNT_CLR,
    input  stall_PC, stall_FD, flush_FD, flush_DE, HALT_ACK,
           STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  RS1_ID, RS2_ID, USE_RS1_ID, USE_RS2_ID, RD_DE, MemRead_DE,
           BR_TAKEN_E, HALT_REQ, CNT_CLR,
    output stall_PC, stall_FD, flush_FD, flush_DE, HALT_ACK,
           STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch redirect
// flushes, debug halt/drain handshake and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int DRAIN_CYCLES    = 2,
  parameter int CNT_W           = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;
  localparam int         SEQ_W       = 16;

  logic [1:0]       state, nxt_state;
  logic [SEQ_W-1:0] cnt, nxt_cnt;
  logic             halt_ack_r, nxt_ack;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             hazard, freeze, flush_fd, flush_de_br;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // rd=x0 never interlocks; a match on both sources is still one hazard
  assign hazard = (hz.MemRead_DE != 2'b00) && (hz.RD_DE != 5'd0) &&
                  ((hz.USE_RS1_ID && (hz.RS1_ID == hz.RD_DE)) ||
                   (hz.USE_RS2_ID && (hz.RS2_ID == hz.RD_DE)));

  // Control decode and next-state: reset beats redirect beats halt beats load-use
  always_comb begin
    freeze      = 1'b0;
    flush_fd    = 1'b0;
    flush_de_br = 1'b0;
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_ack     = halt_ack_r;
    if (RST) begin
      nxt_state = ST_RUN;
    end else if (hz.BR_TAKEN_E) begin
      flush_fd    = 1'b1;
      flush_de_br = 1'b1;
      if (state == ST_LU_STALL) begin
        if (cnt == '0) nxt_state = ST_RUN;
        else           nxt_cnt   = cnt - 1'b1;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (hz.HALT_REQ) begin
            freeze    = 1'b1;
            nxt_state = ST_DRAIN;
            nxt_cnt   = SEQ_W'(DRAIN_CYCLES - 1);
          end else if (hazard) begin
            freeze = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              nxt_state = ST_LU_STALL;
              nxt_cnt   = SEQ_W'(LOAD_USE_CYCLES - 2);
            end
          end
        end
        ST_LU_STALL: begin
          freeze = 1'b1;
          if (cnt == '0) nxt_state = ST_RUN;
          else           nxt_cnt   = cnt - 1'b1;
        end
        ST_DRAIN: begin
          freeze = 1'b1;
          if (!hz.HALT_REQ) begin
            nxt_state = ST_RUN;
          end else if (cnt == '0) begin
            nxt_state = ST_HALTED;
            nxt_ack   = 1'b1;
          end else begin
            nxt_cnt = cnt - 1'b1;
          end
        end
        default: begin
          freeze = 1'b1;
          if (!hz.HALT_REQ) begin
            nxt_state = ST_RUN;
            nxt_ack   = 1'b0;
          end
        end
      endcase
    end
  end

  assign hz.stall_PC  = freeze;
  assign hz.stall_FD  = freeze;
  assign hz.flush_FD  = flush_fd;
  assign hz.flush_DE  = freeze | flush_de_br;
  assign hz.HALT_ACK  = halt_ack_r;
  assign hz.STALL_CNT = stall_cnt_r;
  assign hz.FLUSH_CNT = flush_cnt_r;

  // Sequencer state, remaining-cycle count and registered halt acknowledge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_RUN;
      cnt        <= '0;
      halt_ack_r <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      halt_ack_r <= nxt_ack;
    end
  end

  // Saturating perf counters; clear wins over a same-cycle increment
  always_ff @(posedge CLK) begin
    if (RST || hz.CNT_CLR) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (freeze)        stall_cnt_r <= sat_inc(stall_cnt_r);
      if (hz.BR_TAKEN_E) flush_cnt_r <= sat_inc(flush_cnt_r);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (1-cycle load-use,
// 32-bit counters; 2-cycle load-use, 4-bit counters) share one directed
// stimulus stream; expected outputs are queued per cycle and a negedge
// monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, br = 1'b0, halt = 1'b0, clr = 1'b0;
  logic [1:0] mr = '0;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) if0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if1 ();

  assign if0.RS1_ID = rs1;  assign if1.RS1_ID = rs1;
  assign if0.RS2_ID = rs2;  assign if1.RS2_ID = rs2;
  assign if0.USE_RS1_ID = u1;  assign if1.USE_RS1_ID = u1;
  assign if0.USE_RS2_ID = u2;  assign if1.USE_RS2_ID = u2;
  assign if0.RD_DE = rd;  assign if1.RD_DE = rd;
  assign if0.MemRead_DE = mr;  assign if1.MemRead_DE = mr;
  assign if0.BR_TAKEN_E = br;  assign if1.BR_TAKEN_E = br;
  assign if0.HALT_REQ = halt;  assign if1.HALT_REQ = halt;
  assign if0.CNT_CLR = clr;  assign if1.CNT_CLR = clr;

  pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(1), .DRAIN_CYCLES(2), .CNT_W(32)) dut0 (
    .CLK(CLK), .RST(RST), .hz(if0)
  );
  pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(2), .DRAIN_CYCLES(2), .CNT_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .hz(if1)
  );

  // ctl = {stall_PC, stall_FD, flush_FD, flush_DE}
  typedef struct packed {
    logic [3:0]  ctl;
    logic        ack;
    logic [31:0] sc;
    logic [31:0] fc;
  } obs_t;

  typedef struct packed {
    int   id;
    obs_t o;
  } exp_t;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] FRZ  = 4'b1101;
  localparam logic [3:0] BRF  = 4'b0011;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic e1, input logic e2, input logic [4:0] d,
                       input logic [1:0] m, input logic b, input logic h, input logic c);
    @(posedge CLK);
    #1;
    RST = r; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; mr = m;
    br = b; halt = h; clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect2(input logic [3:0] c0, input logic a0, input int s0, input int f0,
                         input logic [3:0] c1, input logic a1, input int s1, input int f1);
    exp_t e;
    e.id = vec;
    e.o  = '{ctl: c0, ack: a0, sc: 32'(s0), fc: 32'(f0)};
    q0.push_back(e);
    e.o  = '{ctl: c1, ack: a1, sc: 32'(s1), fc: 32'(f1)};
    q1.push_back(e);
    vec++;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queue head
  always @(negedge CLK) begin
    exp_t e;
    obs_t a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = '{ctl: {if0.stall_PC, if0.stall_FD, if0.flush_FD, if0.flush_DE},
            ack: if0.HALT_ACK, sc: if0.STALL_CNT, fc: if0.FLUSH_CNT};
      checks++;
      if (a !== e.o) begin
        errors++;
        $display("FAIL dut0 vec%0d: got ctl=%b ack=%b stall=%0d flush=%0d want ctl=%b ack=%b stall=%0d flush=%0d",
                 e.id, a.ctl, a.ack, a.sc, a.fc, e.o.ctl, e.o.ack, e.o.sc, e.o.fc);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = '{ctl: {if1.stall_PC, if1.stall_FD, if1.flush_FD, if1.flush_DE},
            ack: if1.HALT_ACK, sc: 32'(if1.STALL_CNT), fc: 32'(if1.FLUSH_CNT)};
      checks++;
      if (a !== e.o) begin
        errors++;
        $display("FAIL dut1 vec%0d: got ctl=%b ack=%b stall=%0d flush=%0d want ctl=%b ack=%b stall=%0d flush=%0d",
                 e.id, a.ctl, a.ack, a.sc, a.fc, e.o.ctl, e.o.ack, e.o.sc, e.o.fc);
      end
    end
  end

  initial begin
    // reset held
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect2(NONE, 0, 0, 0, NONE, 0, 0, 0);
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    expect2(NONE, 0, 0, 0, NONE, 0, 0, 0);
    idle();
    expect2(NONE, 0, 0, 0, NONE, 0, 0, 0);
    // load-use on rs1
    drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    expect2(FRZ, 0, 0, 0, FRZ, 0, 0, 0);
    idle();
    expect2(NONE, 0, 1, 0, FRZ, 0, 1, 0);
    idle();
    expect2(NONE, 0, 1, 0, NONE, 0, 2, 0);
    // rd = x0 and unused source: no interlock
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    expect2(NONE, 0, 1, 0, NONE, 0, 2, 0);
    drive(1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    expect2(NONE, 0, 1, 0, NONE, 0, 2, 0);
    // taken branch beats a concurrent hazard
    drive(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 2'd1, 1'b1, 1'b0, 1'b0);
    expect2(BRF, 0, 1, 0, BRF, 0, 2, 0);
    idle();
    expect2(NONE, 0, 1, 1, NONE, 0, 2, 1);
    // hazard on both sources counts once per bubble
    drive(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
    expect2(FRZ, 0, 1, 1, FRZ, 0, 2, 1);
    idle();
    expect2(NONE, 0, 2, 1, FRZ, 0, 3, 1);
    idle();
    expect2(NONE, 0, 2, 1, NONE, 0, 4, 1);
    // halt: request from t, ack from t+3, release at t+5, RUN at t+6
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    expect2(FRZ, 0, 2, 1, FRZ, 0, 4, 1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    expect2(FRZ, 0, 3, 1, FRZ, 0, 5, 1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    expect2(FRZ, 0, 4, 1, FRZ, 0, 6, 1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    expect2(FRZ, 1, 5, 1, FRZ, 1, 7, 1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    expect2(FRZ, 1, 6, 1, FRZ, 1, 8, 1);
    idle();
    expect2(FRZ, 1, 7, 1, FRZ, 1, 9, 1);
    idle();
    expect2(NONE, 0, 8, 1, NONE, 0, 10, 1);
    // reset during DRAIN
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    expect2(FRZ, 0, 8, 1, FRZ, 0, 10, 1);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    expect2(NONE, 0, 9, 1, NONE, 0, 11, 1);
    idle();
    expect2(NONE, 0, 0, 0, NONE, 0, 0, 0);
    // 20 consecutive stall cycles: 4-bit counter sticks at 15
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
      expect2(FRZ, 0, k, 0, FRZ, 0, (k > 15) ? 15 : k, 0);
    end
    // clear overrides the same-cycle stall increment
    drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 2'd2, 1'b0, 1'b0, 1'b1);
    expect2(FRZ, 0, 20, 0, FRZ, 0, 15, 0);
    idle();
    expect2(NONE, 0, 0, 0, FRZ, 0, 0, 0);
    idle();
    expect2(NONE, 0, 0, 0, NONE, 0, 1, 0);
    // flush counter increment then clear
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    expect2(BRF, 0, 0, 0, BRF, 0, 1, 0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    expect2(NONE, 0, 0, 1, NONE, 0, 1, 1);
    idle();
    expect2(NONE, 0, 0, 0, NONE, 0, 0, 0);

    repeat (3) @(posedge CLK);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
